// File: rtl/slot_issue_tracker.sv
// Tracks not-yet-queued slots of the fetched bundle group and grants up to WAYS per cycle in program order.
// Optional single-step limiting via SLOT_DEBUG_STEP_EN; grants are combinational, slotv/partial update next edge.
module slot_issue_tracker #(
  parameter int SLOTS = 6,
  parameter int WAYS  = 2,
  parameter int QW    = $clog2(WAYS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branchmiss,
  input  logic             phit,
  input  logic [SLOTS-1:0] ip_mask,
  input  logic [SLOTS-1:0] slot_jc,
  input  logic [SLOTS-1:0] take_branch,
  input  logic [QW-1:0]    canq,
  input  logic             debug_on,
  output logic [SLOTS-1:0] slotv,
  output logic [SLOTS-1:0] qmask,
  output logic [QW-1:0]    qcnt,
  output logic             adv,
  output logic             partial
);

  logic [SLOTS-1:0] slotv_q, slotv_d;
  logic             partial_q, partial_d;

  logic [SLOTS-1:0] pat;
  logic [SLOTS-1:0] grant;
  logic [QW-1:0]    lim;
  logic [QW-1:0]    cnt;
  logic             cut;
  logic             kill;

`ifndef SLOT_DEBUG_STEP_EN
  logic debug_on_unused;
  assign debug_on_unused = debug_on;
`endif

  always_comb begin
    pat   = slotv_q & {SLOTS{phit}} & ip_mask;
    lim   = (canq > QW'(WAYS)) ? QW'(WAYS) : canq;
`ifdef SLOT_DEBUG_STEP_EN
    if (debug_on && (lim > QW'(1))) lim = QW'(1);
`endif
    grant = '0;
    cnt   = '0;
    cut   = 1'b0;
    // Walk in program order; a jump/call or taken branch ends the group at that slot.
    for (int i = 0; i < SLOTS; i++) begin
      if (pat[i] && !cut && (cnt < lim)) begin
        grant[i] = 1'b1;
        cnt      = cnt + QW'(1);
        if (slot_jc[i] || take_branch[i]) cut = 1'b1;
      end
    end

    kill  = rst | branchmiss;
    qmask = kill ? '0 : grant;
    qcnt  = kill ? '0 : cnt;
    adv   = !kill && (|grant) && (cut || ((pat & ~grant) == '0));

    if (kill || adv) slotv_d = '1;
    else             slotv_d = slotv_q & ~qmask;
    partial_d = (slotv_d != '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slotv_q   <= '1;
      partial_q <= 1'b0;
    end else begin
      slotv_q   <= slotv_d;
      partial_q <= partial_d;
    end
  end

  assign slotv   = slotv_q;
  assign partial = partial_q;

endmodule

// File: tb/tb_slot_issue_tracker.sv
// Directed-vector bench for slot_issue_tracker (SLOTS=6, WAYS=2) with a queued scoreboard and a negedge monitor.
module tb_slot_issue_tracker;

  localparam int SLOTS = 6;
  localparam int WAYS  = 2;
  localparam int QW    = 2;

  logic             clk = 1'b0;
  logic             rst, branchmiss, phit, debug_on;
  logic [SLOTS-1:0] ip_mask, slot_jc, take_branch;
  logic [QW-1:0]    canq;
  logic [SLOTS-1:0] slotv, qmask;
  logic [QW-1:0]    qcnt;
  logic             adv, partial;

  always #5 clk = ~clk;

  slot_issue_tracker #(.SLOTS(SLOTS), .WAYS(WAYS), .QW(QW)) dut (
    .clk(clk), .rst(rst), .branchmiss(branchmiss), .phit(phit),
    .ip_mask(ip_mask), .slot_jc(slot_jc), .take_branch(take_branch),
    .canq(canq), .debug_on(debug_on), .slotv(slotv), .qmask(qmask),
    .qcnt(qcnt), .adv(adv), .partial(partial)
  );

  typedef struct {
    int               id;
    logic [SLOTS-1:0] qmask;
    logic [QW-1:0]    qcnt;
    logic             adv;
    logic [SLOTS-1:0] slotv;
    logic             partial;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;
  bit   stim_done = 0;

  task automatic vec(input logic r, input logic bm, input logic ph,
                     input logic [SLOTS-1:0] ip, input logic [SLOTS-1:0] jc,
                     input logic [SLOTS-1:0] tk, input logic [QW-1:0] cq,
                     input logic dbg, input logic [SLOTS-1:0] e_qm,
                     input logic [QW-1:0] e_qc, input logic e_adv,
                     input logic [SLOTS-1:0] e_sv, input logic e_part);
    exp_t e;
    rst = r; branchmiss = bm; phit = ph; ip_mask = ip; slot_jc = jc;
    take_branch = tk; canq = cq; debug_on = dbg;
    e.id = vec_id; e.qmask = e_qm; e.qcnt = e_qc; e.adv = e_adv;
    e.slotv = e_sv; e.partial = e_part;
    exp_q.push_back(e);
    vec_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s actual=%h required=%h", id, name, act, req);
    end
  endtask

  // Monitor: outputs are valid every driven cycle; pop and compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("qmask",   e.id, 8'(qmask),   8'(e.qmask));
      chk("qcnt",    e.id, 8'(qcnt),    8'(e.qcnt));
      chk("adv",     e.id, 8'(adv),     8'(e.adv));
      chk("slotv",   e.id, 8'(slotv),   8'(e.slotv));
      chk("partial", e.id, 8'(partial), 8'(e.partial));
    end
  end

  initial begin
    rst = 1'b1; branchmiss = 1'b0; phit = 1'b1; ip_mask = 6'h3F;
    slot_jc = '0; take_branch = '0; canq = 2'd2; debug_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //   rst bm ph ip     jc     tk     cq dbg   qmask  qc adv slotv  part
    vec(1, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h00, 0, 0, 6'h3F, 0);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h03, 2, 0, 6'h3F, 0);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h0C, 2, 0, 6'h3C, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h30, 2, 1, 6'h30, 1);
    // taken branch cuts the group
    vec(0, 0, 1, 6'h38, 6'h00, 6'h10, 2, 0,   6'h18, 2, 1, 6'h3F, 0);
    // jump/call in slot 0 truncates slot 1
    vec(0, 0, 1, 6'h3F, 6'h01, 6'h00, 2, 0,   6'h01, 1, 1, 6'h3F, 0);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h03, 2, 0, 6'h3F, 0);
    // branchmiss overrides grant and restarts
    vec(0, 1, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h00, 0, 0, 6'h3C, 1);
    // canq = 0: nothing granted
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 0, 0,   6'h00, 0, 0, 6'h3F, 0);
    // canq = 3 clamps to WAYS
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 3, 0,   6'h03, 2, 0, 6'h3F, 0);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h0C, 2, 0, 6'h3C, 1);
    // phit low: slotv holds at 110000
    vec(0, 0, 0, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h00, 0, 0, 6'h30, 1);
    vec(0, 0, 0, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h00, 0, 0, 6'h30, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 0, 0,   6'h00, 0, 0, 6'h30, 1);
    // rst mid-group: outputs gated, state discarded
    vec(1, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h00, 0, 0, 6'h30, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h03, 2, 0, 6'h3F, 0);
    // ip_mask change mid-group only affects pat
    vec(0, 0, 1, 6'h30, 6'h00, 6'h00, 2, 0,   6'h30, 2, 1, 6'h3C, 1);
    // canq = 1, then a two-wide grant from an odd offset
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 1, 0,   6'h01, 1, 0, 6'h3F, 0);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h06, 2, 0, 6'h3E, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h18, 2, 0, 6'h38, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h20, 1, 1, 6'h20, 1);
    // debug single-step stimulus
`ifdef SLOT_DEBUG_STEP_EN
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 1,   6'h01, 1, 0, 6'h3F, 0);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 1,   6'h02, 1, 0, 6'h3E, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 1,   6'h04, 1, 0, 6'h3C, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 1,   6'h08, 1, 0, 6'h38, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 1,   6'h10, 1, 0, 6'h30, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 1,   6'h20, 1, 1, 6'h20, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h03, 2, 0, 6'h3F, 0);
`else
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 1,   6'h03, 2, 0, 6'h3F, 0);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 1,   6'h0C, 2, 0, 6'h3C, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 1,   6'h30, 2, 1, 6'h30, 1);
    vec(0, 0, 1, 6'h3F, 6'h00, 6'h00, 2, 0,   6'h03, 2, 0, 6'h3F, 0);
`endif
    stim_done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    checks++;
    if (budget >= 2000) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_issue_tracker.md
# slot_issue_tracker

Tracks which instruction slots of the currently fetched bundle group have not yet been queued, and selects up to WAYS slots per cycle for the queue in program order. It is the parametrised successor of the fixed six-slot valid tracker: slot count, queue width and single-step limiting are generic. It also reports the granted slot mask, the grant count and a same-cycle fetch-advance strobe. It sits between the fetch buffer and the instruction queue allocator.

## Interface
- SLOTS, 6, slots per fetched bundle group (2..16)
- WAYS, 2, maximum slots queued per cycle (1..SLOTS)
- QW, $clog2(WAYS+1), width of count fields
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- branchmiss  in  1  pipeline redirect; restarts tracking
- phit  in  1  fetch data valid for current IP
- ip_mask  in  SLOTS  slots at/after the fetch IP
- slot_jc  in  SLOTS  slot is a jump/call (ends group)
- take_branch  in  SLOTS  slot predicted taken (ends group)
- canq  in  QW  free queue entries this cycle (0..WAYS; larger values clamp to WAYS)
- debug_on  in  1  single-step request (see Configuration)
- slotv  out  SLOTS  registered per-slot not-yet-queued flags
- qmask  out  SLOTS  slots granted to the queue this cycle
- qcnt  out  QW  popcount of qmask
- adv  out  1  fetch IP advances to next group this cycle
- partial  out  1  registered; 1 when slotv is not all ones

## Operation
- pat = slotv & {SLOTS{phit}} & ip_mask; bit 0 is oldest in program order.
- lim = min(canq, WAYS); lim = min(lim, 1) when the step limit is active.
- Grant: the lowest-index lim set bits of pat, taken in ascending order.
- Truncation: if a granted slot has slot_jc or take_branch set, all granted slots above it are dropped.
- qmask = the surviving grants; qcnt = popcount(qmask).
- adv = 1 when qmask != 0 and either:
  - a granted slot is jc/taken, or
  - (pat & ~qmask) == 0, meaning the group is exhausted.
- Next state:
  - rst or branchmiss: slotv <= all ones.
  - else if adv: slotv <= all ones.
  - else: slotv <= slotv & ~qmask.
- branchmiss forces qmask = 0, qcnt = 0 and adv = 0 in the same cycle. This overrides any grant.
- pat == 0 (phit low, or no unmasked valid slot): qmask = 0, adv = 0, slotv holds.
- canq == 0: no grant, slotv holds, even when pat != 0.
- A grant sequence that would make slotv all zero instead yields adv = 1 and slotv = all ones.
- ip_mask may change while partial = 1. slotv is not altered by ip_mask changes; only pat is.

## Timing
- qmask, qcnt and adv are combinational from inputs and slotv, so the queue and fetch act in the same cycle.
- slotv and partial update on the following rising edge. Latency from grant to slot invalidation is one clock.
- Reset values: slotv = all ones, partial = 0. qmask = 0, qcnt = 0, adv = 0 whenever rst = 1.
- rst asserted mid-group discards the partial state at the next edge. There is no residual grant.
- rst and branchmiss together behave as rst.

## Configuration
- SLOT_DEBUG_STEP_EN defined: when debug_on = 1, lim is capped at 1, so exactly one slot is granted per cycle.
- SLOT_DEBUG_STEP_EN undefined: debug_on is ignored and lim = min(canq, WAYS) always.
- Port lists are identical in both builds.

## Test plan
- All tests use SLOTS=6, WAYS=2.
- After rst: phit=1, ip_mask=111111, canq=2, no jc/taken.
  - Cycle 1: qmask=000011, slotv -> 111100.
  - Cycle 2: qmask=001100, slotv -> 110000.
  - Cycle 3: qmask=110000, adv=1, slotv -> 111111.
- ip_mask=111000, canq=2, take_branch=010000:
  - qmask=011000 (slot 5 not granted, branch cuts group), adv=1, slotv stays 111111.
- ip_mask=111111, canq=2, slot_jc=000001:
  - qmask=000001, qcnt=1, adv=1; slot 1 is dropped by truncation.
- slotv=111100, canq=2, branchmiss=1:
  - qmask=000000, adv=0, next slotv=111111, partial -> 0.
- With SLOT_DEBUG_STEP_EN: debug_on=1, canq=2, ip_mask=111111.
  - Six successive cycles grant 000001, 000010, 000100, 001000, 010000, 100000.
  - adv=1 only on the sixth cycle.
- Without SLOT_DEBUG_STEP_EN, same stimulus: grants 000011, 001100, 110000.
- phit=0 with slotv=110000 and canq=2: qmask=0, slotv holds 110000 for every cycle phit stays low.
